inst_rom_loader: RTL and testbench

Instruction-side responder for the core's fetch port (rom_ce/rom_addr/rom_data). It serves instruction words from an internal word-addressed memory. A boot-load FSM fills that memory from a byte stream and holds the CPU in reset until the program is loaded. It sits beside the CPU top, driving its rom_data input and its rst.

---
 rtl/inst_rom_loader_pkg.sv | 17 +
 rtl/inst_ram_1w1r.sv | 27 ++
 rtl/inst_rom_loader.sv | 135 +++++++++++++
 tb/tb_inst_rom_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared widths and boot-load state encoding for the instruction ROM loader.
package inst_rom_loader_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

   localparam logic [WORD_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      LD_HDR0 = 2'd0,
      LD_HDR1 = 2'd1,
      LD_DATA = 2'd2,
      LD_RUN  = 2'd3
   } ld_state_e;

endpackage

// File: rtl/inst_ram_1w1r.sv
// Instruction word store: one synchronous write port, one asynchronous read port.
module inst_ram_1w1r
   import inst_rom_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader and fetch responder: fills instruction memory from a byte stream,
// holds the CPU in reset until loaded, then serves same-cycle instruction fetches.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [WORD_W-1:0] rom_addr_i,
   output logic [WORD_W-1:0] rom_data_o,
   input  logic              s_valid_i,
   input  logic [BYTE_W-1:0] s_data_i,
   output logic              s_ready_o,
   input  logic              reload_i,
   output logic              cpu_rst_o,
   output logic              load_done_o,
   output logic              overflow_o,
   output logic [CNT_W-1:0]  words_loaded_o
);

   localparam int unsigned IDX_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   ld_state_e         state_q, state_d;
   logic [1:0]        byte_cnt_q;
   logic [IDX_W-1:0]  wr_idx_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  words_loaded_q;
   logic [23:0]       shift_q;
   logic              overflow_q;

   logic              accept_c;
   logic              word_done_c;
   logic              mem_we_c;
   logic              fetch_hit_c;
   logic [CNT_W-1:0]  hdr_count_c;
   logic [WORD_W-1:0] mem_wdata_c;
   logic [WORD_W-1:0] mem_rdata_c;
   logic              unused_addr_lsb;

   assign s_ready_o   = (state_q != LD_RUN) & ~reload_i & ~rst;
   assign accept_c    = s_valid_i & s_ready_o;
   assign hdr_count_c = {count_q[CNT_W-1:BYTE_W], s_data_i};
   assign word_done_c = accept_c & (state_q == LD_DATA) & (byte_cnt_q == 2'd3);
   // wr_idx saturates at DEPTH; its top bit marks words that are consumed but dropped
   assign mem_we_c    = word_done_c & ~wr_idx_q[ADDR_W];
   assign mem_wdata_c = {shift_q, s_data_i};

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         LD_HDR0: if (accept_c) state_d = LD_HDR1;
         LD_HDR1: if (accept_c) state_d = (hdr_count_c == '0) ? LD_RUN : LD_DATA;
         LD_DATA: begin
            if (word_done_c && ((words_loaded_q + CNT_W'(1)) == count_q)) begin
               state_d = LD_RUN;
            end
         end
         LD_RUN:  state_d = LD_RUN;
         default: state_d = LD_HDR0;
      endcase
      if (reload_i) begin
         state_d = LD_HDR0;
      end
   end

   // State register and registered CPU-facing status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LD_HDR0;
         cpu_rst_o   <= 1'b1;
         load_done_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpu_rst_o   <= (state_d != LD_RUN);
         load_done_o <= (state_d == LD_RUN);
      end
   end

   // Header capture and big-endian word assembly
   always_ff @(posedge clk) begin
      if (rst || reload_i) begin
         byte_cnt_q     <= 2'd0;
         wr_idx_q       <= '0;
         words_loaded_q <= '0;
         overflow_q     <= 1'b0;
      end else if (accept_c) begin
         case (state_q)
            LD_HDR0: count_q[CNT_W-1:BYTE_W] <= s_data_i;
            LD_HDR1: begin
               count_q[BYTE_W-1:0] <= s_data_i;
               if (32'(hdr_count_c) > DEPTH) begin
                  overflow_q <= 1'b1;
               end
            end
            LD_DATA: begin
               if (byte_cnt_q == 2'd3) begin
                  byte_cnt_q     <= 2'd0;
                  words_loaded_q <= words_loaded_q + CNT_W'(1);
                  if (!wr_idx_q[ADDR_W]) begin
                     wr_idx_q <= wr_idx_q + IDX_W'(1);
                  end
               end else begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  shift_q    <= {shift_q[15:0], s_data_i};
               end
            end
            default: ;
         endcase
      end
   end

   assign overflow_o     = overflow_q;
   assign words_loaded_o = words_loaded_q;

   inst_ram_1w1r #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we_c),
      .waddr (wr_idx_q[ADDR_W-1:0]),
      .wdata (mem_wdata_c),
      .raddr (rom_addr_i[ADDR_W+1:2]),
      .rdata (mem_rdata_c)
   );

   // Out-of-range, disabled or pre-RUN fetches return a nop
   assign fetch_hit_c     = rom_ce_i & (state_q == LD_RUN) & (rom_addr_i[WORD_W-1:ADDR_W+2] == '0);
   assign rom_data_o      = fetch_hit_c ? mem_rdata_c : ZERO_WORD;
   assign unused_addr_lsb = ^rom_addr_i[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a byte-queue model checked every cycle on a
// 1024-word and a 4-word instance driven by the same stimulus, plus literal pins.
module tb_inst_rom_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rom_ce, s_valid, reload;
   logic [31:0] rom_addr;
   logic [7:0]  s_data;

   logic [31:0] rom_data_b, rom_data_s;
   logic        s_ready_b, cpu_rst_b, load_done_b, overflow_b;
   logic        s_ready_s, cpu_rst_s, load_done_s, overflow_s;
   logic [15:0] wl_b, wl_s;

   inst_rom_loader dut_b (
      .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data_b),
      .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready_b), .reload_i(reload),
      .cpu_rst_o(cpu_rst_b), .load_done_o(load_done_b), .overflow_o(overflow_b),
      .words_loaded_o(wl_b)
   );

   inst_rom_loader #(.ADDR_W(2)) dut_s (
      .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data_s),
      .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready_s), .reload_i(reload),
      .cpu_rst_o(cpu_rst_s), .load_done_o(load_done_s), .overflow_o(overflow_s),
      .words_loaded_o(wl_s)
   );

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;

   // Model: every byte accepted since the last reset/reload, plus each instance's memory
   logic [7:0]  mq[$];
   logic [31:0] mmem  [2][1024];
   bit          mknown[2][1024];
   int          mdepth[2] = '{1024, 4};
   int          maw   [2] = '{10, 2};

   function automatic int m_count();
      if (mq.size() < 2) return 0;
      return int'({mq[0], mq[1]});
   endfunction

   function automatic int m_words();
      if (mq.size() < 2) return 0;
      return (mq.size() - 2) / 4;
   endfunction

   function automatic bit m_running();
      return (mq.size() >= 2) && (m_words() >= m_count());
   endfunction

   always @(posedge clk) begin : model
      int n, k;
      logic [31:0] w;
      bit run;
      run = m_running();
      if (rst || reload) begin
         mq.delete();
      end else if (s_valid && !run) begin
         mq.push_back(s_data);
         n = mq.size();
         if (n >= 6 && ((n - 2) % 4) == 0) begin
            k = (n - 2) / 4 - 1;
            w = {mq[n-4], mq[n-3], mq[n-2], mq[n-1]};
            for (int m = 0; m < 2; m++) begin
               if (k < mdepth[m]) begin
                  mmem[m][k]   = w;
                  mknown[m][k] = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int m, input logic [31:0] rd, input logic rdy, input logic crst,
                            input logic ldn, input logic ovf, input logic [15:0] wl);
      bit run;
      int idx;
      run = m_running();
      chk($sformatf("s_ready[%0d]", m), 32'(rdy), 32'(!run && !reload && !rst));
      chk($sformatf("cpu_rst[%0d]", m), 32'(crst), 32'(!run));
      chk($sformatf("load_done[%0d]", m), 32'(ldn), 32'(run));
      chk($sformatf("overflow[%0d]", m), 32'(ovf), 32'((mq.size() >= 2) && (m_count() > mdepth[m])));
      chk($sformatf("words_loaded[%0d]", m), 32'(wl), 32'(m_words()));
      if (!rom_ce || !run || ((rom_addr >> (maw[m] + 2)) != 0)) begin
         chk($sformatf("rom_data_nop[%0d]", m), rd, 32'h0);
      end else begin
         idx = int'(rom_addr >> 2) & (mdepth[m] - 1);
         if (mknown[m][idx]) chk($sformatf("rom_data[%0d]", m), rd, mmem[m][idx]);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check_dut(0, rom_data_b, s_ready_b, cpu_rst_b, load_done_b, overflow_b, wl_b);
         check_dut(1, rom_data_s, s_ready_s, cpu_rst_s, load_done_s, overflow_s, wl_s);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered and left just after a rising edge
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int w;
      s_valid = 1'b1;
      s_data  = b;
      w = 0;
      @(negedge clk);
      while (!s_ready_b && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!s_ready_b) begin
         tests++;
         fails++;
         $display("FAIL send_byte_timeout ready=%0b required=1", s_ready_b);
      end
      step();
      s_valid = 1'b0;
      if (gap) step();
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   task automatic fetch_chk(input string name, input int m, input logic ce, input logic [31:0] a,
                            input logic [31:0] exp);
      rom_ce   = ce;
      rom_addr = a;
      @(negedge clk);
      chk(name, (m == 0) ? rom_data_b : rom_data_s, exp);
      step();
      rom_ce = 1'b0;
   endtask

   initial begin
      rst = 1'b1; reload = 1'b0; s_valid = 1'b0; s_data = 8'h00; rom_ce = 1'b0; rom_addr = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checking = 1'b1;
      @(negedge clk);
      chk("reset_cpu_rst", 32'(cpu_rst_b), 32'd1);
      chk("reset_load_done", 32'(load_done_b), 32'd0);
      chk("reset_s_ready", 32'(s_ready_b), 32'd1);
      chk("reset_words", 32'(wl_b), 32'd0);
      chk("reset_overflow", 32'(overflow_b), 32'd0);
      step();

      // 3-word program; CPU reset drops after the 14th accepted byte
      send_byte(8'h00, 0); send_byte(8'h03, 0);
      send_word(32'h34011100, 0); send_word(32'h34020020, 0);
      send_byte(8'h00, 0); send_byte(8'h22, 0); send_byte(8'h18, 0);
      @(negedge clk);
      chk("t1_cpu_rst_before_last", 32'(cpu_rst_b), 32'd1);
      step();
      send_byte(8'h21, 0);
      @(negedge clk);
      chk("t1_cpu_rst_after_last", 32'(cpu_rst_b), 32'd0);
      chk("t1_load_done", 32'(load_done_b), 32'd1);
      chk("t1_words", 32'(wl_b), 32'd3);
      step();
      fetch_chk("t1_fetch_0", 0, 1'b1, 32'h0, 32'h34011100);
      fetch_chk("t1_fetch_8", 0, 1'b1, 32'h8, 32'h00221821);

      // Zero count goes straight to RUN with memory retained
      pulse_reload();
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      @(negedge clk);
      chk("t2_load_done", 32'(load_done_b), 32'd1);
      step();
      fetch_chk("t2_fetch_prior", 0, 1'b1, 32'h0, 32'h34011100);

      // Same image with an idle cycle between every data byte
      pulse_reload();
      send_byte(8'h00, 0); send_byte(8'h03, 0);
      send_word(32'h34011100, 1); send_word(32'h34020020, 1); send_word(32'h00221821, 1);
      @(negedge clk);
      chk("t3_words", 32'(wl_b), 32'd3);
      step();
      fetch_chk("t3_fetch_4", 0, 1'b1, 32'h4, 32'h34020020);
      fetch_chk("t3_fetch_8", 0, 1'b1, 32'h8, 32'h00221821);

      // Reload after six data bytes; the byte offered alongside it is dropped
      pulse_reload();
      send_byte(8'h00, 0); send_byte(8'h03, 0);
      send_word(32'h11223344, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
      @(negedge clk);
      chk("t4_words_before", 32'(wl_b), 32'd1);
      step();
      s_valid = 1'b1; s_data = 8'hAA; reload = 1'b1;
      @(negedge clk);
      chk("t4_ready_during_reload", 32'(s_ready_b), 32'd0);
      step();
      reload = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      chk("t4_words_after", 32'(wl_b), 32'd0);
      chk("t4_cpu_rst_after", 32'(cpu_rst_b), 32'd1);
      step();

      // Five words into the 4-deep instance: fifth is consumed but not stored
      send_byte(8'h00, 0); send_byte(8'h05, 0);
      send_word(32'h0A0B0C0D, 0); send_word(32'h1A1B1C1D, 0); send_word(32'h2A2B2C2D, 0);
      send_word(32'h3A3B3C3D, 0); send_word(32'h4A4B4C4D, 0);
      @(negedge clk);
      chk("t5_overflow_small", 32'(overflow_s), 32'd1);
      chk("t5_overflow_big", 32'(overflow_b), 32'd0);
      chk("t5_words_small", 32'(wl_s), 32'd5);
      chk("t5_run_small", 32'(load_done_s), 32'd1);
      step();
      fetch_chk("t5_small_fetch_c", 1, 1'b1, 32'hC, 32'h3A3B3C3D);
      fetch_chk("t5_small_fetch_10", 1, 1'b1, 32'h10, 32'h0);
      fetch_chk("t5_big_fetch_10", 0, 1'b1, 32'h10, 32'h4A4B4C4D);

      // Fetch gating
      fetch_chk("t6_ce_low", 0, 1'b0, 32'h0, 32'h0);
      fetch_chk("t6_addr_high", 0, 1'b1, 32'h0000_1000, 32'h0);
      fetch_chk("t6_addr_7_big", 0, 1'b1, 32'h7, 32'h1A1B1C1D);
      fetch_chk("t6_addr_7_small", 1, 1'b1, 32'h7, 32'h1A1B1C1D);
      pulse_reload();
      fetch_chk("t6_load_state", 0, 1'b1, 32'h0, 32'h0);

      // Reset part-way through a load behaves like reload
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t7_cpu_rst", 32'(cpu_rst_b), 32'd1);
      chk("t7_words", 32'(wl_b), 32'd0);
      chk("t7_ready", 32'(s_ready_b), 32'd1);
      step();

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
